// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: complex sample word, bit-reversal, default frame size.
package fft_pkg;

  localparam int FFT_N_DEFAULT  = 16;
  localparam int FFT_DW_DEFAULT = 16;
  localparam int FFT_LOG2N_MAX  = 9;

  typedef struct packed {
    logic [FFT_DW_DEFAULT-1:0] re;
    logic [FFT_DW_DEFAULT-1:0] im;
  } cplx_t;

  // Reverse the full-width index, then shift down so only the low nbits are mirrored.
  function automatic logic [FFT_LOG2N_MAX-1:0] bitrev(input logic [FFT_LOG2N_MAX-1:0] idx,
                                                      input int nbits);
    logic [FFT_LOG2N_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < FFT_LOG2N_MAX; i++) begin
      r[i] = idx[FFT_LOG2N_MAX-1-i];
    end
    return r >> (FFT_LOG2N_MAX - nbits);
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N_POINTS-deep sample bank: synchronous write port, combinational read port.
// No reset on the storage; the owner tracks which contents are valid.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int  N_POINTS = FFT_N_DEFAULT,
  parameter type word_t   = cplx_t,
  localparam int AW       = $clog2(N_POINTS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [N_POINTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder via ping-pong banks; index 0 out one cycle after a frame's last write.
// Input cannot stall: samples arriving while both banks are full are dropped (overflow; ovf_cnt with FFT_REORDER_OVF_CNT_EN).
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = FFT_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  input  logic                  out_ready,
  output logic                  out_val,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last,
  output logic                  overflow
`ifdef FFT_REORDER_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_cnt
`endif
);

  localparam int               LOG2N    = $clog2(N_POINTS);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } word_t;

  logic [1:0]               full;
  logic                     wr_bank, rd_bank;
  logic [LOG2N-1:0]         wr_cnt, rd_cnt;
  logic                     wr_en, wr_last, wr_drop, rd_load, rd_last;
  logic [FFT_LOG2N_MAX-1:0] wr_rev;
  logic [LOG2N-1:0]         wr_addr;
  word_t                    wr_word, rd_word;
  word_t                    bank_rd [2];

  assign wr_en   = in_val && !full[wr_bank];
  assign wr_drop = in_val && full[wr_bank];
  assign wr_last = wr_en && (wr_cnt == LAST_IDX);
  assign wr_rev  = bitrev(FFT_LOG2N_MAX'(wr_cnt), LOG2N);
  assign wr_addr = wr_rev[LOG2N-1:0];
  assign wr_word = '{re: in_re, im: in_im};

  assign rd_load = full[rd_bank] && (!out_val || out_ready);
  assign rd_last = rd_load && (rd_cnt == LAST_IDX);
  assign rd_word = bank_rd[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .N_POINTS (N_POINTS),
      .word_t   (word_t)
    ) u_bank (
      .clk   (clk),
      .we    (wr_en && (wr_bank == 1'(b))),
      .waddr (wr_addr),
      .wdata (wr_word),
      .raddr (rd_cnt),
      .rdata (bank_rd[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_load) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  // Writer only fills a non-full bank and reader only drains a full one, so set and clear never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_last && (wr_bank == 1'(b)))      full[b] <= 1'b1;
        else if (rd_last && (rd_bank == 1'(b))) full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val  <= 1'b0;
      out_last <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
    end else if (rd_load) begin
      out_val  <= 1'b1;
      out_last <= (rd_cnt == LAST_IDX);
      out_re   <= rd_word.re;
      out_im   <= rd_word.im;
    end else if (out_ready) begin
      out_val  <= 1'b0;
      out_last <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (wr_drop) overflow <= 1'b1;
  end

`ifdef FFT_REORDER_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              ovf_cnt <= '0;
    else if (wr_drop && ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: natural order, streaming, backpressure, overflow, async reset.
module tb_fft_bitrev_reorder;

  localparam int DW    = 16;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic [DW-1:0] in_re, in_im;
  logic          out_ready;
  logic          out_val;
  logic [DW-1:0] out_re, out_im;
  logic          out_last;
  logic          overflow;
`ifdef FFT_REORDER_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_drive_cyc = 0;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .overflow  (overflow)
`ifdef FFT_REORDER_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (((k >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // Natural-order frame is re=base_re+j, im=base_im-j; it is sent in bit-reversed order.
  task automatic send_frame(input int base_re, input int base_im, input bit push, input int nsamp);
    logic [DW-1:0] nre [N];
    logic [DW-1:0] nim [N];
    for (int j = 0; j < N; j++) begin
      nre[j] = DW'(base_re + j);
      nim[j] = DW'(base_im - j);
      if (push) sb.push_back('{re: nre[j], im: nim[j], last: (j == N - 1)});
    end
    for (int k = 0; k < nsamp; k++) begin
      @(posedge clk); #1;
      in_val = 1'b1;
      in_re  = nre[brev(k)];
      in_im  = nim[brev(k)];
      last_drive_cyc = cyc;
    end
  endtask

  task automatic stop_input();
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_val = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL rst_out_val: got %b want 0", out_val); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (out_re !== '0) begin failures++; $display("FAIL rst_out_re: got %0h want 0", out_re); end
    checks++; if (out_im !== '0) begin failures++; $display("FAIL rst_out_im: got %0h want 0", out_im); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_natural();
    int n = 0;
    int budget = 200;
    bit seen = 0;
    exp_t e;
    out_ready = 1'b1;
    fork
      begin send_frame(0, 0, 1, N); stop_input(); end
      begin
        while (n < N && budget > 0) begin
          @(negedge clk); budget--;
          if (out_val && out_ready) begin
            if (!seen) begin
              seen = 1; checks++;
              if (cyc !== last_drive_cyc + 2) begin
                failures++; $display("FAIL nat_latency: first out_val at cycle %0d want %0d", cyc, last_drive_cyc + 2);
              end
            end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({out_re, out_im, out_last} !== {e.re, e.im, e.last}) begin
              failures++; $display("FAIL nat_word%0d: got re=%0d im=%0h last=%b want re=%0d im=%0h last=%b",
                                   n, out_re, out_im, out_last, e.re, e.im, e.last);
            end
            n++;
          end
        end
      end
    join
    checks++; if (n != N) begin failures++; $display("FAIL nat_count: got %0d words want %0d", n, N); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int budget = 400;
    int bubbles = 0;
    exp_t e;
    out_ready = 1'b1;
    fork
      begin
        for (int f = 0; f < 4; f++) send_frame(100 * (f + 1), 1000 * (f + 1), 1, N);
        stop_input();
      end
      begin
        while (n < 4 * N && budget > 0) begin
          @(negedge clk); budget--;
          if (n > 0 && !out_val) bubbles++;
          if (out_val && out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({out_re, out_im, out_last} !== {e.re, e.im, e.last}) begin
              failures++; $display("FAIL b2b_word%0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                                   n, out_re, out_im, out_last, e.re, e.im, e.last);
            end
            n++;
          end
        end
      end
    join
    checks++; if (n != 4 * N) begin failures++; $display("FAIL b2b_count: got %0d words want %0d", n, 4 * N); end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int budget = 200;
    bit stalled = 0;
    logic [DW-1:0] held_im;
    exp_t e;
    out_ready = 1'b1;
    fork
      begin send_frame(0, 200, 1, N); stop_input(); end
      begin
        while (n < N && budget > 0) begin
          @(negedge clk); budget--;
          if (!stalled && out_val && out_re == DW'(6)) begin
            stalled = 1;
            out_ready = 1'b0;
            held_im = out_im;
            repeat (5) begin
              @(negedge clk);
              checks++;
              if (out_val !== 1'b1 || out_re !== DW'(6) || out_im !== held_im) begin
                failures++; $display("FAIL bp_hold: got val=%b re=%0d im=%0d want val=1 re=6 im=%0d",
                                     out_val, out_re, out_im, held_im);
              end
            end
            out_ready = 1'b1;
          end
          if (out_val && out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({out_re, out_im, out_last} !== {e.re, e.im, e.last}) begin
              failures++; $display("FAIL bp_word%0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                                   n, out_re, out_im, out_last, e.re, e.im, e.last);
            end
            n++;
          end
        end
      end
    join
    checks++; if (!stalled || n != N) begin failures++; $display("FAIL bp_count: got %0d words stalled=%b want %0d stalled=1", n, stalled, N); end
  endtask

  task automatic test_overflow();
    int n = 0;
    int budget = 300;
    exp_t e;
    out_ready = 1'b0;
    send_frame(2000, 3000, 1, N);
    send_frame(4000, 5000, 1, N);
    send_frame(6000, 7000, 0, N);
    stop_input();
    repeat (3) @(negedge clk);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`ifdef FFT_REORDER_OVF_CNT_EN
    checks++; if (ovf_cnt !== 8'd16) begin failures++; $display("FAIL ovf_cnt: got %0d want 16", ovf_cnt); end
`endif
    out_ready = 1'b1;
    while (n < 2 * N && budget > 0) begin
      @(negedge clk); budget--;
      if (out_val && out_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({out_re, out_im, out_last} !== {e.re, e.im, e.last}) begin
          failures++; $display("FAIL ovf_word%0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                               n, out_re, out_im, out_last, e.re, e.im, e.last);
        end
        n++;
      end
    end
    repeat (20) @(negedge clk);
    checks++; if (n != 2 * N || out_val !== 1'b0) begin failures++; $display("FAIL ovf_drain: got %0d words val=%b want %0d val=0", n, out_val, 2 * N); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int budget = 200;
    exp_t e;
    out_ready = 1'b0;
    send_frame(500, 700, 0, N);
    send_frame(800, 900, 0, 7);
    #1 in_val = 1'b0;
    checks++; if (out_val !== 1'b1 || out_re !== DW'(500)) begin failures++; $display("FAIL rstmid_pre: got val=%b re=%0d want val=1 re=500", out_val, out_re); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({out_val, out_last, out_re, out_im, overflow} !== '0) begin
      failures++; $display("FAIL rstmid_async: got val=%b last=%b re=%0d im=%0d ovf=%b want all 0",
                           out_val, out_last, out_re, out_im, overflow);
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    out_ready = 1'b1;
    fork
      begin send_frame(30, 40, 1, N); stop_input(); end
      begin
        while (n < N && budget > 0) begin
          @(negedge clk); budget--;
          if (out_val && out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({out_re, out_im, out_last} !== {e.re, e.im, e.last}) begin
              failures++; $display("FAIL rstmid_word%0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                                   n, out_re, out_im, out_last, e.re, e.im, e.last);
            end
            n++;
          end
        end
      end
    join
    repeat (5) @(negedge clk);
    checks++; if (n != N || out_val !== 1'b0) begin failures++; $display("FAIL rstmid_count: got %0d words val=%b want %0d val=0", n, out_val, N); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
